ysyx_22041211_ifu_fetch: RTL and testbench
==========================================

// Module: ysyx_22041211_ifu_fetch
// PURPOSE
//   Instruction fetch stage directly downstream of the PC register.
//   - Takes the current PC and issues one read request per instruction on a valid/ready memory port.
//   - Captures the response and presents {inst, pc, fault} to the decode stage through a valid/ready handshake.
//   - Pulses pc_wen_o when decode accepts an instruction, so the PC register advances.
//   - Only one fetch is outstanding at a time; the stage is non-pipelined.
// PARAMETERS
//   ADDR_LEN  32  width of PC and memory address
//   INST_LEN  32  width of instruction word
// PORTS
//   clk              in   1         clock; all state updates on the rising edge
//   rst              in   1         asynchronous reset, ACTIVE-LOW (0 = reset)
//   pc_i             in   ADDR_LEN  current PC from the PC register
//   pc_wen_o         out  1         1-cycle pulse: instruction handed to decode, PC may advance
//   flush_i          in   1         redirect from execute; drop the fetch in flight
//   mem_req_valid_o  out  1         read request valid
//   mem_req_ready_i  in   1         memory accepts request
//   mem_req_addr_o   out  ADDR_LEN  read address
//   mem_rsp_valid_i  in   1         read data valid
//   mem_rsp_ready_o  out  1         fetch accepts read data
//   mem_rsp_data_i   in   INST_LEN  read data
//   mem_rsp_err_i    in   1         bus error qualifying the read data
//   inst_valid_o     out  1         instruction valid to decode
//   inst_ready_i     in   1         decode accepts instruction
//   inst_o           out  INST_LEN  instruction word
//   inst_pc_o        out  ADDR_LEN  PC of inst_o
//   inst_fault_o     out  1         fetch fault (misaligned PC or bus error)
// BEHAVIOUR
//   Reset (rst=0, asynchronous, any state): state=IDLE, drop=0, all outputs 0.
//   FSM transitions:
//   - IDLE: next cycle -> REQ.
//   - REQ: addr_q <= pc_i on entry.
//       - If pc_i[1:0]!=0: no request is issued; -> HOLD with inst=0, fault=1.
//       - Otherwise: mem_req_valid_o=1, mem_req_addr_o=addr_q. Valid and addr stay stable until mem_req_ready_i=1; then -> WAIT.
//   - WAIT: mem_rsp_ready_o=1 (0 in every other state).
//       - On mem_rsp_valid_i, if drop=1: discard the data, clear drop, -> REQ.
//       - On mem_rsp_valid_i, if drop=0: capture data, err and addr_q; -> HOLD.
//   - HOLD: inst_valid_o=1; inst_o, inst_pc_o and inst_fault_o stay stable while valid is high.
//       - On inst_ready_i=1: pc_wen_o=1 for that cycle; -> REQ.
//   Flush handling:
//   - flush in REQ before the handshake: the request is not withdrawn. Once accepted, set drop=1.
//   - flush in WAIT: set drop=1. If the response arrives in the same cycle, discard it and -> REQ.
//   - flush in HOLD: inst_valid_o drops next cycle, no pc_wen_o pulse, -> REQ.
//   - flush in IDLE: no effect.
//   - flush takes priority over inst_ready_i in the same cycle.
//   REQ always re-samples pc_i on entry, so a redirect that the PC register latched during flush is picked up.
//   Latency: with zero-wait memory, REQ cycle n (accept), response n+1, inst_valid_o n+2.
//     Decode accept at n+2 gives the next REQ at n+3, i.e. 3 cycles per instruction minimum.
//   Back-to-back: pc_wen_o is never asserted twice without an intervening memory response or fault.
// TESTING
//   1. Reset release, pc_i=0x80000000, mem ready/rsp zero-wait -> req addr 0x80000000 at cycle 1;
//      inst_valid_o at cycle 3 with inst_pc_o=0x80000000; pc_wen_o pulses on inst_ready_i.
//   2. mem_req_ready_i low for 4 cycles -> mem_req_valid_o held high, addr stable; no duplicate request.
//   3. flush_i in WAIT, response 0xDEADBEEF arrives 2 cycles later -> response discarded,
//      no inst_valid_o, new request at redirected pc_i=0x80000100.
//   4. pc_i=0x80000002 -> no mem request; inst_valid_o=1, inst_fault_o=1, inst_o=0.
//   5. mem_rsp_err_i=1 -> inst_fault_o=1; inst_ready_i held low 5 cycles ->
//      outputs stable, pc_wen_o=0 throughout.
//   6. rst=0 asserted mid-WAIT -> all outputs 0 immediately (asynchronous);
//      after release, fetch restarts from IDLE.

Source files
------------

// File: rtl/ysyx_22041211_ifu_fetch.sv
// Instruction fetch stage: one read per PC, response presented to decode as {inst, pc, fault}.
// Latency: zero-wait memory gives request at n, response at n+1, inst_valid at n+2 (3 cycles/inst).
// Backpressure: request held stable until mem_req_ready_i; instruction held stable until inst_ready_i.
//
// Ports:
//   clk, rst           clock (rising edge) and asynchronous active-low reset
//   pc_i / pc_wen_o    current PC in; one-cycle advance pulse when decode takes an instruction
//   flush_i            redirect from execute; the fetch in flight is thrown away
//   mem_req_*          valid/ready read request (addr)
//   mem_rsp_*          valid/ready read response (data, err)
//   inst_*             valid/ready instruction to decode (inst, pc, fault)
module ysyx_22041211_ifu_fetch #(
    parameter int ADDR_LEN = 32,
    parameter int INST_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] pc_i,
    output logic                pc_wen_o,
    input  logic                flush_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_LEN-1:0] mem_req_addr_o,
    input  logic                mem_rsp_valid_i,
    output logic                mem_rsp_ready_o,
    input  logic [INST_LEN-1:0] mem_rsp_data_i,
    input  logic                mem_rsp_err_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [INST_LEN-1:0] inst_o,
    output logic [ADDR_LEN-1:0] inst_pc_o,
    output logic                inst_fault_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t              state_q, state_d;
    // entry_q marks the first cycle of REQ. The PC register advances (pc_wen_o)
    // or takes a redirect (flush_i) on the same edge that moves us into REQ, so
    // pc_i is only trustworthy from that first REQ cycle onwards; it is used
    // live then and frozen into addr_q for the rest of the request.
    logic                entry_q, entry_d;
    // drop_q: the outstanding request belongs to a flushed path; its response
    // must be swallowed rather than handed to decode.
    logic                drop_q, drop_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [INST_LEN-1:0] inst_q, inst_d;
    logic                fault_q, fault_d;

    logic [ADDR_LEN-1:0] req_addr;
    logic                misaligned;

    assign req_addr   = entry_q ? pc_i : addr_q;
    assign misaligned = (req_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            entry_q <= 1'b0;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        entry_d         = 1'b0;
        drop_d          = drop_q;
        addr_d          = addr_q;
        inst_d          = inst_q;
        fault_d         = fault_q;
        mem_req_valid_o = 1'b0;
        mem_rsp_ready_o = 1'b0;
        inst_valid_o    = 1'b0;
        pc_wen_o        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                entry_d = 1'b1;
            end

            ST_REQ: begin
                addr_d = req_addr;
                if (misaligned) begin
                    // Nothing was sent to memory, so a flush here simply
                    // restarts REQ on the redirected PC.
                    if (flush_i) begin
                        entry_d = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        inst_d  = '0;
                        fault_d = 1'b1;
                    end
                end else begin
                    // A request once raised is never withdrawn; a flush only
                    // marks its eventual response as stale.
                    mem_req_valid_o = 1'b1;
                    if (flush_i) begin
                        drop_d = 1'b1;
                    end
                    if (mem_req_ready_i) begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                mem_rsp_ready_o = 1'b1;
                if (mem_rsp_valid_i) begin
                    if (drop_q || flush_i) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                        entry_d = 1'b1;
                    end else begin
                        inst_d  = mem_rsp_data_i;
                        fault_d = mem_rsp_err_i;
                        state_d = ST_HOLD;
                    end
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end

            ST_HOLD: begin
                inst_valid_o = 1'b1;
                // Flush wins over a simultaneous decode accept: the PC must
                // take the redirect, not advance.
                if (flush_i) begin
                    state_d = ST_REQ;
                    entry_d = 1'b1;
                end else if (inst_ready_i) begin
                    pc_wen_o = 1'b1;
                    state_d  = ST_REQ;
                    entry_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_req_addr_o = req_addr;
    assign inst_o         = inst_q;
    assign inst_pc_o      = addr_q;
    assign inst_fault_o   = fault_q;

endmodule

// File: tb/tb_ysyx_22041211_ifu_fetch.sv
// Bench for the fetch stage: the bench plays PC register, memory and decode.
// Reference rule: every instruction decode accepts is the memory word at the PC register value.
// Random ready/latency/flush segments follow a set of directed scenarios.
module tb_ysyx_22041211_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i;
    logic        pc_wen_o;
    logic        flush_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic        mem_rsp_ready_o;
    logic [31:0] mem_rsp_data_i;
    logic        mem_rsp_err_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_fault_o;

    ysyx_22041211_ifu_fetch #(.ADDR_LEN(32), .INST_LEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc_i),
        .pc_wen_o        (pc_wen_o),
        .flush_i         (flush_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_ready_o (mem_rsp_ready_o),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_err_i   (mem_rsp_err_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_fault_o    (inst_fault_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory image: a fixed function of the address; every 32nd word faults.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a[6:2] == 5'd31);
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = 32'h8000_0000 + ($urandom_range(63) << 2);
        if ($urandom_range(7) == 0) t = t + 32'd2;
        return t;
    endfunction

    // Environment state
    logic [31:0] pc_reg;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] pend_word;
    int unsigned pend_dly;
    int unsigned p_req_rdy, p_inst_rdy, p_flush, dly_min, dly_max;
    logic        force_flush;
    logic [31:0] redir_pc;
    logic        prev_reqwait, prev_hold;
    logic [31:0] prev_addr;
    logic [64:0] prev_inst;
    logic        last_req_hs;
    logic [31:0] last_req_addr;
    int          delivered = 0;
    int          n_req_hs;
    int          stall;
    logic        abort = 1'b0;

    task automatic do_reset(input logic [31:0] pc);
        rst             = 1'b0;
        flush_i         = 1'b0;
        inst_ready_i    = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = 32'h0;
        mem_rsp_err_i   = 1'b0;
        pend            = 1'b0;
        pend_addr       = 32'h0;
        pend_word       = 32'h0;
        pend_dly        = 0;
        force_flush     = 1'b0;
        redir_pc        = 32'h0;
        prev_reqwait    = 1'b0;
        prev_hold       = 1'b0;
        prev_addr       = 32'h0;
        prev_inst       = '0;
        last_req_hs     = 1'b0;
        last_req_addr   = 32'h0;
        n_req_hs        = 0;
        stall           = 0;
        pc_reg          = pc;
        pc_i            = pc;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, observe shortly before the rising edge.
    task automatic step();
        logic        req_hs, rsp_hs, inst_hs;
        logic [31:0] nxt;
        @(negedge clk);
        pc_i            = pc_reg;
        mem_req_ready_i = ($urandom_range(99) < p_req_rdy);
        mem_rsp_valid_i = pend && (pend_dly == 0);
        mem_rsp_data_i  = pend ? pend_word : $urandom;
        mem_rsp_err_i   = pend ? mem_err(pend_addr) : ($urandom_range(1) == 1);
        inst_ready_i    = ($urandom_range(99) < p_inst_rdy);
        if (force_flush) begin
            flush_i     = 1'b1;
            nxt         = redir_pc;
            force_flush = 1'b0;
        end else if ($urandom_range(99) < p_flush) begin
            flush_i = 1'b1;
            nxt     = rand_target();
        end else begin
            flush_i = 1'b0;
            nxt     = pc_reg;
        end
        #3;
        req_hs  = mem_req_valid_o && mem_req_ready_i;
        rsp_hs  = mem_rsp_valid_i && mem_rsp_ready_o;
        inst_hs = inst_valid_o && inst_ready_i && !flush_i;

        check("pc_wen", pc_wen_o, inst_hs);
        check("rsp_rdy_outstanding", mem_rsp_ready_o, pend);
        if (prev_reqwait) begin
            check("req_hold_vld", mem_req_valid_o, 1);
            check("req_hold_addr", mem_req_addr_o, prev_addr);
        end
        if (prev_hold) begin
            check("inst_hold_vld", inst_valid_o, 1);
            check("inst_hold_dat", {inst_fault_o, inst_o, inst_pc_o}, prev_inst);
        end

        if (rsp_hs) pend = 1'b0;
        else if (pend && pend_dly > 0) pend_dly--;

        last_req_hs = req_hs;
        if (req_hs) begin
            check("one_outstanding", pend, 0);
            check("req_align", mem_req_addr_o[1:0], 0);
            pend          = 1'b1;
            pend_addr     = mem_req_addr_o;
            pend_word     = mem_word(mem_req_addr_o);
            pend_dly      = $urandom_range(dly_max, dly_min);
            last_req_addr = mem_req_addr_o;
            n_req_hs++;
        end

        if (inst_hs) begin
            check("inst_pc", inst_pc_o, pc_reg);
            if (pc_reg[1:0] != 2'b00) begin
                check("inst_dat", inst_o, 0);
                check("inst_fault", inst_fault_o, 1);
            end else begin
                check("inst_dat", inst_o, mem_word(pc_reg));
                check("inst_fault", inst_fault_o, mem_err(pc_reg));
            end
            pc_reg = pc_reg + 32'd4;
            delivered++;
            stall = 0;
        end else begin
            stall++;
        end
        if (flush_i) pc_reg = nxt;

        prev_reqwait = mem_req_valid_o && !mem_req_ready_i;
        prev_addr    = mem_req_addr_o;
        prev_hold    = inst_valid_o && !inst_ready_i && !flush_i;
        prev_inst    = {inst_fault_o, inst_o, inst_pc_o};

        if (stall > 500 && !abort) begin
            check("watchdog_stall", stall, 0);
            abort = 1'b1;
        end
    endtask

    task automatic run_until_delivered(input string tag, input int budget);
        int d0;
        d0 = delivered;
        for (int i = 0; i < budget && delivered == d0; i++) step();
        check(tag, (delivered != d0), 1);
    endtask

    task automatic set_knobs(input int unsigned rr, input int unsigned dmin, input int unsigned dmax,
                             input int unsigned ir, input int unsigned fl);
        p_req_rdy  = rr;
        dly_min    = dmin;
        dly_max    = dmax;
        p_inst_rdy = ir;
        p_flush    = fl;
    endtask

    initial begin
        int  d0;
        logic saw, got;

        // 1: zero-wait latency and PC advance
        set_knobs(100, 0, 0, 0, 0);
        do_reset(32'h8000_0000);
        step();
        check("t1_req_vld_c1", mem_req_valid_o, 1);
        check("t1_req_addr_c1", mem_req_addr_o, 32'h8000_0000);
        step();
        check("t1_no_inst_c2", inst_valid_o, 0);
        step();
        check("t1_inst_vld_c3", inst_valid_o, 1);
        check("t1_inst_pc_c3", inst_pc_o, 32'h8000_0000);
        p_inst_rdy = 100;
        step();
        check("t1_pc_wen_c4", pc_wen_o, 1);
        step();
        check("t1_next_req_addr", {31'd0, mem_req_valid_o, mem_req_addr_o}, {31'd0, 1'b1, 32'h8000_0004});

        // 2: request backpressure holds valid/addr, single request issued
        set_knobs(0, 0, 0, 100, 0);
        do_reset(32'h8000_0040);
        repeat (5) begin
            step();
            check("t2_req_vld", mem_req_valid_o, 1);
            check("t2_req_addr", mem_req_addr_o, 32'h8000_0040);
        end
        check("t2_no_hs_yet", n_req_hs, 0);
        p_req_rdy = 100;
        run_until_delivered("t2_deliver", 10);
        check("t2_one_req", n_req_hs, 1);

        // 3: flush in WAIT, stale response 2 cycles later is discarded
        set_knobs(100, 2, 2, 100, 0);
        do_reset(32'h8000_0000);
        step();
        check("t3_req_hs", last_req_hs, 1);
        pend_word   = 32'hDEAD_BEEF;
        force_flush = 1'b1;
        redir_pc    = 32'h8000_0100;
        d0  = delivered;
        saw = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            if (inst_valid_o) saw = 1'b1;
            if (last_req_hs) got = 1'b1;
        end
        check("t3_no_inst", saw, 0);
        check("t3_redirect_req", got ? last_req_addr : 32'h0, 32'h8000_0100);
        check("t3_none_delivered", delivered - d0, 0);
        run_until_delivered("t3_deliver", 12);

        // 4: misaligned PC faults without touching memory
        set_knobs(100, 0, 0, 0, 0);
        do_reset(32'h8000_0002);
        step();
        check("t4_no_req", mem_req_valid_o, 0);
        step();
        check("t4_inst_vld", inst_valid_o, 1);
        check("t4_fault", inst_fault_o, 1);
        check("t4_inst_zero", inst_o, 0);
        check("t4_inst_pc", inst_pc_o, 32'h8000_0002);
        check("t4_no_mem", n_req_hs, 0);
        p_inst_rdy = 100;
        run_until_delivered("t4_deliver", 4);

        // 5: bus error, decode stalls 5 cycles
        set_knobs(100, 0, 0, 0, 0);
        do_reset(32'h8000_007C);
        repeat (3) step();
        check("t5_inst_vld", inst_valid_o, 1);
        check("t5_fault", inst_fault_o, 1);
        repeat (5) begin
            step();
            check("t5_no_wen", pc_wen_o, 0);
        end
        check("t5_fault_held", {inst_valid_o, inst_fault_o, inst_pc_o}, {1'b1, 1'b1, 32'h8000_007C});
        p_inst_rdy = 100;
        run_until_delivered("t5_deliver", 4);

        // 6: asynchronous reset mid-WAIT, then clean restart
        set_knobs(100, 20, 20, 100, 0);
        do_reset(32'h8000_0010);
        step();
        step();
        check("t6_in_wait", mem_rsp_ready_o, 1);
        rst = 1'b0;
        #1;
        check("t6_ctl_zero", {mem_req_valid_o, mem_rsp_ready_o, inst_valid_o, inst_fault_o, pc_wen_o}, 0);
        check("t6_dat_zero", {mem_req_addr_o, inst_pc_o}, 0);
        check("t6_inst_zero", inst_o, 0);
        set_knobs(100, 0, 0, 100, 0);
        do_reset(32'h8000_0010);
        step();
        check("t6_restart_req", {31'd0, mem_req_valid_o, mem_req_addr_o}, {31'd0, 1'b1, 32'h8000_0010});
        run_until_delivered("t6_deliver", 6);

        // Random segments
        do_reset(32'h8000_0000 + ($urandom_range(63) << 2));
        d0 = delivered;
        for (int s = 0; s < 12 && !abort; s++) begin
            set_knobs($urandom_range(100, 30), 0, $urandom_range(3), $urandom_range(100, 20),
                      $urandom_range(6));
            for (int c = 0; c < 250 && !abort; c++) step();
        end
        check("rand_progress", (delivered - d0) > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
